// File: rtl/matrix_scan_driver.sv
// Double-buffered LED matrix scan driver: collects a frame of rows, then shifts each
// row out serially, latches it and holds it lit. Define SCAN_MIRROR_EN to shift LSB first.
module matrix_scan_driver #(
   parameter int WIDTH       = 80,
   parameter int ROWS        = 41,
   parameter int HOLD_CYCLES = 16,
   parameter int AW          = 6
) (
   input  logic             cnt,
   input  logic             rst,
   input  logic [WIDTH-1:0] row_in,
   input  logic             row_valid,
   input  logic             frame_start,
   output logic             row_ready,
   output logic             ser_data,
   output logic             ser_clk,
   output logic             ser_latch,
   output logic [AW-1:0]    row_addr,
   output logic             blank,
   output logic             frame_done
);
   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, SHOW} scanState_t;

   localparam int            CW         = $clog2(2*WIDTH + HOLD_CYCLES + 1);
   localparam logic [CW-1:0] SHIFT_LAST = CW'(2*WIDTH - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [AW-1:0] ROW_LAST   = AW'(ROWS - 1);

   logic [WIDTH-1:0] frameMem [2][ROWS];
   scanState_t       state, stateNxt;
   logic [CW-1:0]    stepCnt;
   logic [AW-1:0]    rowIdx, wptr, wIdx, rowAddrQ;
   logic [WIDTH-1:0] shiftReg, shifted;
   logic             bankSel, backFull, frontValid;
   logic             accept, swapNow, doLoad, outBit, rowEnd;

`ifdef SCAN_MIRROR_EN
   assign outBit  = shiftReg[0];
   assign shifted = {1'b0, shiftReg[WIDTH-1:1]};
`else
   assign outBit  = shiftReg[WIDTH-1];
   assign shifted = {shiftReg[WIDTH-2:0], 1'b0};
`endif

   assign row_ready = !backFull;
   assign accept    = row_valid && row_ready;
   assign wIdx      = frame_start ? '0 : wptr;
   assign row_addr  = rowAddrQ;

   // The swap cycle out of IDLE doubles as the LOAD of row 0, so shifting starts next cycle.
   always_comb begin
      stateNxt   = state;
      blank      = 1'b1;
      ser_clk    = 1'b0;
      ser_data   = 1'b0;
      ser_latch  = 1'b0;
      frame_done = 1'b0;
      rowEnd     = 1'b0;
      swapNow    = 1'b0;
      doLoad     = 1'b0;
      case (state)
         IDLE:  if (backFull) stateNxt = SHIFT;
         LOAD:  stateNxt = frontValid ? SHIFT : IDLE;
         SHIFT: begin
            ser_data = outBit;
            ser_clk  = stepCnt[0];
            if (stepCnt == SHIFT_LAST) stateNxt = LATCH;
         end
         LATCH: begin
            ser_latch = 1'b1;
            stateNxt  = SHOW;
         end
         SHOW: begin
            blank = 1'b0;
            if (stepCnt == HOLD_LAST) begin
               rowEnd     = 1'b1;
               stateNxt   = LOAD;
               frame_done = (rowIdx == ROW_LAST);
            end
         end
         default: stateNxt = IDLE;
      endcase
      swapNow = backFull && (state == IDLE || frame_done);
      doLoad  = (state == LOAD) || (state == IDLE && backFull);
   end

   // Frame store is never cleared; only the bank not on display is written.
   always_ff @(posedge cnt) begin
      if (accept) frameMem[~bankSel][wIdx] <= row_in;
   end

   always_ff @(posedge cnt) begin
      if (rst) begin
         state      <= IDLE;
         stepCnt    <= '0;
         rowIdx     <= '0;
         rowAddrQ   <= '0;
         shiftReg   <= '0;
         wptr       <= '0;
         backFull   <= 1'b0;
         frontValid <= 1'b0;
         bankSel    <= 1'b0;
      end else begin
         state   <= stateNxt;
         stepCnt <= (stateNxt != state || state == IDLE) ? '0 : stepCnt + 1'b1;
         if (rowEnd) rowIdx <= (rowIdx == ROW_LAST) ? '0 : rowIdx + 1'b1;
         if (state == LATCH) rowAddrQ <= rowIdx;
         if (doLoad) shiftReg <= frameMem[bankSel ^ swapNow][rowIdx];
         else if (state == SHIFT && stepCnt[0]) shiftReg <= shifted;
         if (swapNow) begin
            bankSel    <= ~bankSel;
            frontValid <= 1'b1;
            backFull   <= 1'b0;
         end
         if (accept) begin
            if (frame_start) wptr <= AW'(1);
            else if (wptr == ROW_LAST) begin
               wptr     <= '0;
               backFull <= 1'b1;
            end else wptr <= wptr + 1'b1;
         end
      end
   end
endmodule
